// File: rtl/unary_pkg.sv
// Shared types and helpers for the multi-operand unary adder.
// Vector helpers take a MAX_BITS-wide argument; callers zero-extend, which is safe for both checks.
package unary_pkg;

  localparam int MAX_BITS = 256;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SORT = 3'b010,
    DONE = 3'b100
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Sorted means ones packed toward bit 0: no 0 directly below a 1.
  function automatic logic is_sorted(input logic [MAX_BITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_BITS - 1; i++) begin
      if (!v[i] && v[i+1]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Index of the 1->0 edge plus one; equals the count for a packed vector.
  function automatic logic [15:0] thermo_to_bin(input logic [MAX_BITS-1:0] v);
    logic [MAX_BITS:0] x;
    logic [15:0]       r;
    x = {1'b0, v};
    r = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (x[i] && !x[i+1]) r = 16'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/unary_cx_layer.sv
// One combinational odd/even compare-exchange layer; pairs (j, j+1) with j matching parity.
module unary_cx_layer #(
  parameter int N = 16
) (
  input  logic         parity,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_comb begin
    q = d;
    for (int j = 0; j < N - 1; j++) begin
      if (1'(j % 2) == parity) begin
        q[j]   = d[j] | d[j+1];
        q[j+1] = d[j] & d[j+1];
      end
    end
  end

endmodule

// File: rtl/unary_multi_adder.sv
// Multi-operand thermometer adder: sorts the concatenated operands with an odd-even
// transposition network (PASSES layers per clock) and reports the packed vector and its count.
module unary_multi_adder
  import unary_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_OPS    = 4,
  parameter int PASSES     = 1,
  parameter int EARLY_EXIT = 1,
  localparam int TOTAL     = WIDTH * NUM_OPS,
  localparam int CW        = clog2(TOTAL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TOTAL-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TOTAL-1:0] out_data,
  output logic [CW-1:0]    out_sum,
  output logic             busy
);

  localparam int PW = clog2(TOTAL + PASSES + 1);

  state_t           state, state_nx;
  logic [TOTAL-1:0] work;
  logic [PW-1:0]    phase, phase_nx;
  logic [TOTAL-1:0] stage [PASSES+1];
  logic [PASSES-1:0] par;
  logic [MAX_BITS-1:0] work_ext;
  logic             sorted, early_hit;
  logic [CW-1:0]    sum_w;

  assign stage[0] = work;

  for (genvar l = 0; l < PASSES; l++) begin : g_layer
    assign par[l] = phase[0] ^ 1'(l % 2);
    unary_cx_layer #(.N(TOTAL)) u_layer (
      .parity (par[l]),
      .d      (stage[l]),
      .q      (stage[l+1])
    );
  end

  assign work_ext  = MAX_BITS'(work);
  assign sorted    = is_sorted(work_ext);
  assign early_hit = (EARLY_EXIT != 0) && sorted;
  assign sum_w     = CW'(thermo_to_bin(work_ext));
  assign phase_nx  = phase + PW'(PASSES);

  assign in_ready = (state == IDLE);
  assign busy     = (state == SORT) || (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SORT;
      SORT:    if (early_hit || (phase_nx >= PW'(TOTAL))) state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are captured on the first DONE edge, so out_valid trails the DONE entry by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      phase     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            phase <= '0;
          end
        end
        SORT: begin
          if (!early_hit) begin
            work  <= stage[PASSES];
            phase <= phase_nx;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= work;
            out_sum   <= sum_w;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_multi_adder.sv
// Bench for three 16-bit configurations of unary_multi_adder: vector table, corner sequences, random.
module tb_unary_multi_adder;

  localparam int T  = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [T-1:0]  in_data   [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [T-1:0]  out_data  [3];
  logic [CW-1:0] out_sum   [3];
  logic          busy      [3];

  int n_vec = 0;
  int n_err = 0;
  int p_of  [3] = '{1, 1, 4};
  int ee_of [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  unary_multi_adder #(.WIDTH(8), .NUM_OPS(2), .PASSES(1), .EARLY_EXIT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_sum(out_sum[0]), .busy(busy[0]));
  unary_multi_adder #(.WIDTH(8), .NUM_OPS(2), .PASSES(1), .EARLY_EXIT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_sum(out_sum[1]), .busy(busy[1]));
  unary_multi_adder #(.WIDTH(8), .NUM_OPS(2), .PASSES(4), .EARLY_EXIT(0)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_sum(out_sum[2]), .busy(busy[2]));

  typedef struct {
    int          k;
    logic [15:0] din;
    logic [15:0] exp_data;
    int          exp_sum;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (dut%0d): got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sort by bit-swapping (0 below 1 moves the 1 down) in alternating-parity phases.
  function automatic logic [15:0] apply_phases(input logic [15:0] v, input int n);
    logic [15:0] b;
    logic        t;
    b = v;
    for (int p = 0; p < n; p++) begin
      for (int j = p % 2; j + 1 < T; j += 2) begin
        if (!b[j] && b[j+1]) begin
          t = b[j]; b[j] = b[j+1]; b[j+1] = t;
        end
      end
    end
    return b;
  endfunction

  function automatic bit packed_ok(input logic [15:0] v);
    int pc;
    logic [31:0] t;
    pc = $countones(v);
    t  = (32'd1 << pc) - 32'd1;
    return v == t[15:0];
  endfunction

  function automatic logic [15:0] model_data(input logic [15:0] v);
    logic [31:0] t;
    t = (32'd1 << $countones(v)) - 32'd1;
    return t[15:0];
  endfunction

  function automatic int model_lat(input int k, input logic [15:0] v);
    int full;
    full = (T + p_of[k] - 1) / p_of[k];
    if (ee_of[k] != 0) begin
      for (int c = 0; c < full; c++)
        if (packed_ok(apply_phases(v, c * p_of[k]))) return c + 2;
    end
    return full + 1;
  endfunction

  task automatic run_op(input int k, input logic [15:0] din, input logic [15:0] ed,
                        input int es, input int el, input string tag);
    int lat;
    int w;
    w = 0;
    while (!in_ready[k] && w < 50) begin tick(); w++; end
    in_valid[k] = 1'b1;
    in_data[k]  = din;
    tick();
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 100) begin tick(); lat++; end
    chk({tag, " latency"}, k, 32'(lat), 32'(el));
    chk({tag, " out_data"}, k, 32'(out_data[k]), 32'(ed));
    chk({tag, " out_sum"}, k, 32'(out_sum[k]), 32'(es));
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    chk({tag, " valid cleared"}, k, 32'(out_valid[k]), 32'd0);
    chk({tag, " back to idle"}, k, 32'(in_ready[k]), 32'd1);
  endtask

  initial begin
    vec_t tbl[6];
    logic [15:0] r;
    int w;

    tbl[0] = '{0, 16'h1F07, 16'h00FF, 8, 17};
    tbl[1] = '{0, 16'h00A0, 16'h0003, 2, 17};
    tbl[2] = '{1, 16'h0000, 16'h0000, 0, 2};
    tbl[3] = '{1, 16'hFFFF, 16'hFFFF, 16, 2};
    tbl[4] = '{2, 16'h8001, 16'h0003, 2, 5};
    tbl[5] = '{1, 16'h00FF, 16'h00FF, 8, 2};

    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("reset out_valid", k, 32'(out_valid[k]), 32'd0);
      chk("reset out_data", k, 32'(out_data[k]), 32'd0);
      chk("reset out_sum", k, 32'(out_sum[k]), 32'd0);
      chk("reset in_ready", k, 32'(in_ready[k]), 32'd1);
      chk("reset busy", k, 32'(busy[k]), 32'd0);
    end

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].k, tbl[i].din, tbl[i].exp_data, tbl[i].exp_sum, tbl[i].exp_lat, $sformatf("vec%0d", i));

    // Backpressure in DONE with in_valid toggling: nothing may change or be captured.
    in_valid[0] = 1'b1; in_data[0] = 16'h0F0F;
    tick();
    in_valid[0] = 1'b0;
    w = 0;
    while (!out_valid[0] && w < 100) begin tick(); w++; end
    chk("bp reach done", 0, 32'(out_valid[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = (i % 2 == 0);
      in_data[0]  = 16'hFFFF;
      tick();
      chk("bp out_valid held", 0, 32'(out_valid[0]), 32'd1);
      chk("bp out_data held", 0, 32'(out_data[0]), 32'h00FF);
      chk("bp out_sum held", 0, 32'(out_sum[0]), 32'd8);
      chk("bp in_ready low", 0, 32'(in_ready[0]), 32'd0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("bp release valid", 0, 32'(out_valid[0]), 32'd0);
    chk("bp release idle", 0, 32'(in_ready[0]), 32'd1);
    chk("bp release busy", 0, 32'(busy[0]), 32'd0);
    chk("bp data kept", 0, 32'(out_data[0]), 32'h00FF);
    run_op(0, 16'h3000, 16'h0003, 2, 17, "post-bp");

    // Abort mid-sort after five phases.
    in_valid[0] = 1'b1; in_data[0] = 16'h0101;
    tick();
    in_valid[0] = 1'b0;
    repeat (5) tick();
    chk("midsort busy", 0, 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort out_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("abort out_data", 0, 32'(out_data[0]), 32'd0);
    chk("abort out_sum", 0, 32'(out_sum[0]), 32'd0);
    chk("abort busy", 0, 32'(busy[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("abort in_ready", 0, 32'(in_ready[0]), 32'd1);
    chk("abort stays idle", 0, 32'(out_valid[0]), 32'd0);
    run_op(0, 16'h0101, 16'h0003, 2, 17, "post-abort");

    for (int i = 0; i < 30; i++) begin
      int k;
      k = i % 3;
      r = 16'($urandom);
      if (i % 7 == 1) r = 16'($urandom_range(0, 3)) == 0 ? 16'h0000 : model_data(r);
      run_op(k, r, model_data(r), $countones(r), model_lat(k, r), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
